debounce_edge_detect: RTL and testbench

- Consumes the registered single-bit output of the rising-edge D flip-flop input stage (its Q).
- Qualifies that bit as stable only after it holds one value for STABLE_CYCLES consecutive clock samples.
- Presents the qualified level plus one-cycle rise/fall strobes to downstream control logic.
- Fully synchronous to the same clock; no internal CDC.

---
 rtl/debounce_edge_detect_pkg.sv | 15 +
 rtl/debounce_edge_detect_if.sv | 29 ++
 rtl/debounce_edge_detect_stable_counter.sv | 30 +++
 rtl/debounce_edge_detect.sv | 132 +++++++++++++
 tb/tb_debounce_edge_detect.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_edge_detect_pkg.sv
// Shared definitions for the debounce / edge-detect block: FSM state
// encoding and the default qualification counter width.
package debounce_pkg;

    // Encoding chosen so bit 1 reflects the currently accepted level.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b11,
        WAIT_LOW  = 2'b10
    } state_t;

    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/debounce_edge_detect_if.sv
// Signal bundle between the debouncer and its neighbours: the registered
// input bit coming in, and the qualified level plus strobes going out.
interface debounce_edge_detect_if;

    logic din;
    logic level;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    // Environment side: supplies din, observes the debounced results.
    modport master (
        output din,
        input  level,
        input  rise_pulse,
        input  fall_pulse,
        input  busy
    );

    // Debouncer side.
    modport slave (
        input  din,
        output level,
        output rise_pulse,
        output fall_pulse,
        output busy
    );

endinterface

// File: rtl/debounce_edge_detect_stable_counter.sv
// Counts consecutive agreeing samples while a candidate level is being
// qualified; hit flags the last sample needed before acceptance.
module stable_counter
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int          CNT_W         = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             hit
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(STABLE_CYCLES - 1);

    // Clear wins over increment; the FSM never asks to count past TERMINAL.
    always_ff @(posedge clk) begin
        if (sync_reset || clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign hit = (cnt == TERMINAL);

endmodule

// File: rtl/debounce_edge_detect.sv
// Debounces a registered single-bit input: a new level is accepted only
// after STABLE_CYCLES consecutive identical samples, then a one-cycle
// rise or fall strobe is emitted. All outputs are registered.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   IDLE_LOW  | level is 0, din agrees
//   WAIT_HIGH | level is 0, din has been 1 for cnt samples
//   IDLE_HIGH | level is 1, din agrees
//   WAIT_LOW  | level is 1, din has been 0 for cnt samples
module debounce_edge_detect
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter bit          RESET_LEVEL   = 1'b0,
    parameter int          CNT_W         = CNT_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   sync_reset,
    debounce_edge_detect_if.slave  bus
);

    localparam bit     SINGLE      = (STABLE_CYCLES == 1);
    localparam state_t RESET_STATE = RESET_LEVEL ? IDLE_HIGH : IDLE_LOW;

    state_t           state;
    logic             clear;
    logic             inc;
    logic             hit;
    logic [CNT_W-1:0] cnt;

    stable_counter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_stable_counter (
        .clk        (clk),
        .sync_reset (sync_reset),
        .clear      (clear),
        .inc        (inc),
        .cnt        (cnt),
        .hit        (hit)
    );

    // Counter control: the first disagreeing sample in IDLE counts as 1,
    // any abort or acceptance clears back to 0.
    always_comb begin
        clear = 1'b0;
        inc   = 1'b0;
        case (state)
            IDLE_LOW:  inc = bus.din && !SINGLE;
            WAIT_HIGH: if (!bus.din || hit) clear = 1'b1; else inc = 1'b1;
            IDLE_HIGH: inc = !bus.din && !SINGLE;
            WAIT_LOW:  if (bus.din || hit) clear = 1'b1; else inc = 1'b1;
            default:   clear = 1'b1;
        endcase
    end

    // State register and registered outputs; strobes default low each cycle.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state          <= RESET_STATE;
            bus.level      <= RESET_LEVEL;
            bus.rise_pulse <= 1'b0;
            bus.fall_pulse <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            bus.rise_pulse <= 1'b0;
            bus.fall_pulse <= 1'b0;
            bus.busy       <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (bus.din) begin
                        if (SINGLE) begin
                            state          <= IDLE_HIGH;
                            bus.level      <= 1'b1;
                            bus.rise_pulse <= 1'b1;
                        end else begin
                            state    <= WAIT_HIGH;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (!bus.din) begin
                        state <= IDLE_LOW;
                    end else if (hit) begin
                        state          <= IDLE_HIGH;
                        bus.level      <= 1'b1;
                        bus.rise_pulse <= 1'b1;
                    end else begin
                        bus.busy <= 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    if (!bus.din) begin
                        if (SINGLE) begin
                            state          <= IDLE_LOW;
                            bus.level      <= 1'b0;
                            bus.fall_pulse <= 1'b1;
                        end else begin
                            state    <= WAIT_LOW;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                WAIT_LOW: begin
                    if (bus.din) begin
                        state <= IDLE_HIGH;
                    end else if (hit) begin
                        state          <= IDLE_LOW;
                        bus.level      <= 1'b0;
                        bus.fall_pulse <= 1'b1;
                    end else begin
                        bus.busy <= 1'b1;
                    end
                end
                default: begin
                    state     <= RESET_STATE;
                    bus.level <= RESET_LEVEL;
                end
            endcase
        end
    end

    // The qualification count is bounded by construction and never wraps.
    always_ff @(posedge clk) begin
        if (!sync_reset) begin
            assert (cnt <= CNT_W'(STABLE_CYCLES - 1));
        end
    end

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed bench for debounce_edge_detect. Three instances cover the
// default configuration (N=4, reset low), N=1, and reset-high.
// Observed word per instance is {level, rise_pulse, fall_pulse, busy}.
module tb_debounce_edge_detect;
    import debounce_pkg::*;

    logic clk = 1'b0;
    logic sync_reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #10 clk = ~clk;

    debounce_edge_detect_if if_a ();
    debounce_edge_detect_if if_b ();
    debounce_edge_detect_if if_c ();

    debounce_edge_detect #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b0), .CNT_W(16)) dut_a (
        .clk(clk), .sync_reset(sync_reset), .bus(if_a));
    debounce_edge_detect #(.STABLE_CYCLES(1), .RESET_LEVEL(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .sync_reset(sync_reset), .bus(if_b));
    debounce_edge_detect #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b1), .CNT_W(16)) dut_c (
        .clk(clk), .sync_reset(sync_reset), .bus(if_c));

    wire [3:0] obs_a = {if_a.level, if_a.rise_pulse, if_a.fall_pulse, if_a.busy};
    wire [3:0] obs_b = {if_b.level, if_b.rise_pulse, if_b.fall_pulse, if_b.busy};
    wire [3:0] obs_c = {if_c.level, if_c.rise_pulse, if_c.fall_pulse, if_c.busy};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [3:0] exp;
        sync_reset = 1'b1;
        if_a.din = 1'b1;
        if_b.din = 1'b0;
        if_c.din = 1'b1;
        tick();
        n_vec++;
        if (obs_a !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_a: got %b expected %b", obs_a, 4'b0000);
        end
        n_vec++;
        if (obs_b !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_b: got %b expected %b", obs_b, 4'b0000);
        end
        n_vec++;
        if (obs_c !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_c: got %b expected %b", obs_c, 4'b1000);
        end
        #14;
        sync_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp = (i < 3) ? 4'b0001 : (i == 3) ? 4'b1100 : 4'b1000;
            n_vec++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL reset_release step %0d: got %b expected %b", i, obs_a, exp);
            end
        end
    endtask

    task automatic test_clean_rise_fall;
        logic [2:0] phases;
        logic       v;
        logic [3:0] exp;
        int         n_rise;
        int         n_fall;
        phases = 3'b010;
        for (int p = 0; p < 3; p++) begin
            v = phases[p];
            if_a.din = v;
            n_rise = 0;
            n_fall = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (if_a.rise_pulse === 1'b1) n_rise++;
                if (if_a.fall_pulse === 1'b1) n_fall++;
                exp = {(i >= 3) ? v : ~v, (i == 3) && v, (i == 3) && !v, i < 3};
                n_vec++;
                if (obs_a !== exp) begin
                    n_err++;
                    $display("FAIL clean phase %0d step %0d: got %b expected %b", p, i, obs_a, exp);
                end
            end
            n_vec++;
            if (n_rise != (v ? 1 : 0) || n_fall != (v ? 0 : 1)) begin
                n_err++;
                $display("FAIL clean_count phase %0d: got rise=%0d fall=%0d expected rise=%0d fall=%0d",
                         p, n_rise, n_fall, v ? 1 : 0, v ? 0 : 1);
            end
        end
    endtask

    task automatic test_glitch;
        logic [3:0] exp;
        if_a.din = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (obs_a !== 4'b0001) begin
                n_err++;
                $display("FAIL glitch_high step %0d: got %b expected %b", i, obs_a, 4'b0001);
            end
        end
        if_a.din = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (obs_a !== 4'b0000) begin
                n_err++;
                $display("FAIL glitch_abort step %0d: got %b expected %b", i, obs_a, 4'b0000);
            end
        end
        if_a.din = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp = (i < 3) ? 4'b0001 : (i == 3) ? 4'b1100 : 4'b1000;
            n_vec++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL glitch_then_rise step %0d: got %b expected %b", i, obs_a, exp);
            end
        end
        if_a.din = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp = (i < 3) ? 4'b1001 : (i == 3) ? 4'b0010 : 4'b0000;
            n_vec++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL glitch_restore step %0d: got %b expected %b", i, obs_a, exp);
            end
        end
    endtask

    task automatic test_reset_mid_qual;
        logic [3:0] exp;
        if_a.din = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (obs_a !== 4'b0001) begin
                n_err++;
                $display("FAIL midq_pre step %0d: got %b expected %b", i, obs_a, 4'b0001);
            end
        end
        sync_reset = 1'b1;
        tick();
        n_vec++;
        if (obs_a !== 4'b0000) begin
            n_err++;
            $display("FAIL midq_reset: got %b expected %b", obs_a, 4'b0000);
        end
        sync_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp = (i < 3) ? 4'b0001 : (i == 3) ? 4'b1100 : 4'b1000;
            n_vec++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL midq_release step %0d: got %b expected %b", i, obs_a, exp);
            end
        end
        if_a.din = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_single_cycle;
        logic [9:0] pat;
        logic       prev;
        logic [3:0] exp;
        pat  = 10'b0011001011;
        prev = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if_b.din = pat[i];
            tick();
            exp = {pat[i], pat[i] && !prev, !pat[i] && prev, 1'b0};
            n_vec++;
            if (obs_b !== exp) begin
                n_err++;
                $display("FAIL single step %0d: got %b expected %b", i, obs_b, exp);
            end
            prev = pat[i];
        end
        if_b.din = 1'b0;
        tick();
    endtask

    task automatic test_reset_level_one;
        logic [3:0] exp;
        sync_reset = 1'b1;
        if_c.din   = 1'b0;
        tick();
        n_vec++;
        if (obs_c !== 4'b1000) begin
            n_err++;
            $display("FAIL rl1_reset: got %b expected %b", obs_c, 4'b1000);
        end
        sync_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp = (i < 3) ? 4'b1001 : (i == 3) ? 4'b0010 : 4'b0000;
            n_vec++;
            if (obs_c !== exp) begin
                n_err++;
                $display("FAIL rl1_fall step %0d: got %b expected %b", i, obs_c, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise_fall();
        test_glitch();
        test_reset_mid_qual();
        test_single_cycle();
        test_reset_level_one();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
